// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and digit type for the BCD digit adder
//   BCD_MAX     : largest legal decimal digit value
//   BCD_CORR    : value added to a binary sum above BCD_MAX to wrap it into decimal
//   bcd_digit_t : one 4-bit BCD digit
//   bcd_over    : true when a 4-bit value is not a legal decimal digit
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic bcd_over(input bcd_digit_t d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_full_adder.sv
// rtl/bcd_full_adder.sv - one-bit full adder cell used by the BCD digit adder
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module bcd_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/bcd_add.sv
// rtl/bcd_add.sv - registered single-digit BCD adder slice (binary and decimal results)
//   clk              : system clock, rising edge
//   rst              : asynchronous active-high reset, clears all outputs
//   a3..a0, b3..b0   : operand digits, bit 3 is the MSB
//   cin              : carry in from the lower digit slice
//   s3..s0, cout     : registered raw binary sum a+b+cin
//   S3..S0, Cout     : registered decimal-corrected digit and decimal carry
//   err              : registered operand-out-of-range flag (only with BCD_ADD_ERR_EN)
// Optional feature macro: BCD_ADD_ERR_EN
module bcd_add
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a3,
  input  logic a2,
  input  logic a1,
  input  logic a0,
  input  logic b3,
  input  logic b2,
  input  logic b1,
  input  logic b0,
  input  logic cin,
  output logic s3,
  output logic s2,
  output logic s1,
  output logic s0,
  output logic cout,
  output logic S3,
  output logic S2,
  output logic S1,
  output logic S0,
  output logic Cout
`ifdef BCD_ADD_ERR_EN
  ,
  output logic err
`endif
);

  bcd_digit_t a;
  bcd_digit_t b;
  bcd_digit_t bin_sum;
  logic [4:0] ripple;
  logic       corr;
  bcd_digit_t dec_sum;
  logic       corr_c2;
  logic       corr_c3;

  assign a = {a3, a2, a1, a0};
  assign b = {b3, b2, b1, b0};

  // Binary stage: four-cell ripple, ripple[4] is bit 4 of a+b+cin.
  assign ripple[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_ripple
    bcd_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (ripple[i]),
      .s  (bin_sum[i]),
      .co (ripple[i+1])
    );
  end

  // Binary result above 9: carry out, or 1x1x / 11xx in the low nibble.
  assign corr = ripple[4] | (bin_sum[3] & bin_sum[2]) | (bin_sum[3] & bin_sum[1]);

  // Correction stage adds {0, corr, corr, 0} (i.e. BCD_CORR or 0) mod 16.
  // Bit 0 of the addend is always 0, so bit 0 passes through; bit 3 of the
  // addend is also 0, so only the incoming carry toggles it and its own
  // carry (the discarded mod-16 overflow) is never formed.
  assign dec_sum[0] = bin_sum[0];

  bcd_full_adder u_corr1 (
    .a  (bin_sum[1]),
    .b  (corr & BCD_CORR[1]),
    .ci (1'b0),
    .s  (dec_sum[1]),
    .co (corr_c2)
  );

  bcd_full_adder u_corr2 (
    .a  (bin_sum[2]),
    .b  (corr & BCD_CORR[2]),
    .ci (corr_c2),
    .s  (dec_sum[2]),
    .co (corr_c3)
  );

  assign dec_sum[3] = bin_sum[3] ^ corr_c3;

  // Both result sets load on the same edge so they always describe one sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {cout, s3, s2, s1, s0} <= 5'd0;
      {Cout, S3, S2, S1, S0} <= 5'd0;
    end else begin
      {cout, s3, s2, s1, s0} <= {ripple[4], bin_sum};
      {Cout, S3, S2, S1, S0} <= {corr, dec_sum};
    end
  end

`ifdef BCD_ADD_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= bcd_over(a) | bcd_over(b);
    end
  end
`endif

endmodule

// File: tb/tb_bcd_add.sv
// tb/tb_bcd_add.sv - self-checking bench for bcd_add against a decimal-rule reference model
module tb_bcd_add;

  logic clk;
  logic rst;
  logic a3, a2, a1, a0;
  logic b3, b2, b1, b0;
  logic cin;
  logic s3, s2, s1, s0, cout;
  logic S3, S2, S1, S0, Cout;
`ifdef BCD_ADD_ERR_EN
  logic err;
`endif

  int checks = 0;
  int errors = 0;

  bcd_add dut (
    .clk  (clk),
    .rst  (rst),
    .a3   (a3),
    .a2   (a2),
    .a1   (a1),
    .a0   (a0),
    .b3   (b3),
    .b2   (b2),
    .b1   (b1),
    .b0   (b0),
    .cin  (cin),
    .s3   (s3),
    .s2   (s2),
    .s1   (s1),
    .s0   (s0),
    .cout (cout),
    .S3   (S3),
    .S2   (S2),
    .S1   (S1),
    .S0   (S0),
    .Cout (Cout)
`ifdef BCD_ADD_ERR_EN
    ,
    .err  (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout, s[3:0], Cout, S[3:0]} from plain integer arithmetic.
  function automatic logic [9:0] model(input int av, input int bv, input int cv);
    int total;
    int dig;
    logic dc;
    total = av + bv + cv;
    if (total > 9) begin
      dig = (total + 6) % 16;
      dc  = 1'b1;
    end else begin
      dig = total;
      dc  = 1'b0;
    end
    return {total[4:0], dc, dig[3:0]};
  endfunction

  function automatic logic [9:0] observed();
    return {cout, s3, s2, s1, s0, Cout, S3, S2, S1, S0};
  endfunction

  task automatic drive(input int av, input int bv, input int cv);
    logic [3:0] ta;
    logic [3:0] tb;
    ta = av[3:0];
    tb = bv[3:0];
    {a3, a2, a1, a0} = ta;
    {b3, b2, b1, b0} = tb;
    cin = cv[0];
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    rst = 1'b1;
    drive(9, 9, 1);
    #2;
    if (observed() !== 10'd0) begin
      errors++;
      $display("FAIL reset_initial got=%b want=%b", observed(), 10'd0);
    end
    checks++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp = model(9, 9, 1);
    if (observed() !== exp) begin
      errors++;
      $display("FAIL reset_release got=%b want=%b", observed(), exp);
    end
    checks++;
    // Mid-cycle assertion must clear outputs without a clock edge.
    #1 rst = 1'b1;
    #1;
    if (observed() !== 10'd0) begin
      errors++;
      $display("FAIL reset_async got=%b want=%b", observed(), 10'd0);
    end
    checks++;
    drive(7, 5, 0);
    #1 rst = 1'b0;
    #1;
    if (observed() !== 10'd0) begin
      errors++;
      $display("FAIL reset_hold_until_edge got=%b want=%b", observed(), 10'd0);
    end
    checks++;
    @(posedge clk); #1;
    exp = model(7, 5, 0);
    if (observed() !== exp) begin
      errors++;
      $display("FAIL reset_first_edge got=%b want=%b", observed(), exp);
    end
    checks++;
`ifdef BCD_ADD_ERR_EN
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got=%b want=0", err);
    end
    checks++;
`endif
  endtask

  task automatic test_directed();
    int tab_a[6]   = '{5, 7, 8, 9, 9, 15};
    int tab_b[6]   = '{3, 5, 1, 0, 9, 15};
    int tab_c[6]   = '{0, 0, 1, 0, 1, 1};
    logic [9:0] want[6];
    want[0] = {1'b0, 4'b1000, 1'b0, 4'b1000};
    want[1] = {1'b0, 4'b1100, 1'b1, 4'b0010};
    want[2] = {1'b0, 4'b1010, 1'b1, 4'b0000};
    want[3] = {1'b0, 4'b1001, 1'b0, 4'b1001};
    want[4] = {1'b1, 4'b0011, 1'b1, 4'b1001};
    want[5] = {1'b1, 4'b1111, 1'b1, 4'b0101};
    for (int i = 0; i < 6; i++) begin
      drive(tab_a[i], tab_b[i], tab_c[i]);
      @(posedge clk); #1;
      if (observed() !== want[i]) begin
        errors++;
        $display("FAIL directed_%0d a=%0d b=%0d cin=%0d got=%b want=%b",
                 i, tab_a[i], tab_b[i], tab_c[i], observed(), want[i]);
      end
      checks++;
`ifdef BCD_ADD_ERR_EN
      if (err !== (tab_a[i] > 9 || tab_b[i] > 9)) begin
        errors++;
        $display("FAIL directed_err_%0d got=%b", i, err);
      end
      checks++;
`endif
    end
  endtask

  task automatic test_sweep();
    logic [9:0] exp;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          drive(av, bv, cv);
          @(posedge clk); #1;
          exp = model(av, bv, cv);
          if (observed() !== exp) begin
            errors++;
            $display("FAIL sweep a=%0d b=%0d cin=%0d got=%b want=%b",
                     av, bv, cv, observed(), exp);
          end
          checks++;
`ifdef BCD_ADD_ERR_EN
          if (err !== (av > 9 || bv > 9)) begin
            errors++;
            $display("FAIL sweep_err a=%0d b=%0d got=%b", av, bv, err);
          end
          checks++;
`endif
        end
      end
    end
  endtask

  // Random back-to-back stream, plus a check that the output holds the
  // previous sample until the next edge.
  task automatic test_back_to_back();
    int av, bv, cv;
    logic [9:0] exp;
    for (int n = 0; n < 200; n++) begin
      av = int'($urandom_range(15, 0));
      bv = int'($urandom_range(15, 0));
      cv = int'($urandom_range(1, 0));
      drive(av, bv, cv);
      @(posedge clk); #1;
      exp = model(av, bv, cv);
      drive(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), int'($urandom_range(1, 0)));
      #2;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL random a=%0d b=%0d cin=%0d got=%b want=%b",
                 av, bv, cv, observed(), exp);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
